// File: rtl/freq_to_dig_pkg.sv
// ----------------------------------------------------------------------------
// freq_to_dig_pkg
//   Shared types and helpers for the multi-channel frequency-to-digital
//   converter (freq_to_dig_mc) and its per-channel counter slice.
//
//   state_t  : measurement sequencer states.
//   gate_w() : width of the gate-window counter for a given window length.
//              This is a function rather than a fixed localparam so that each
//              instance can size its counter from its own GATE_CYCLES.
// ----------------------------------------------------------------------------
package freq_to_dig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  // $clog2(GATE_CYCLES); GATE_CYCLES >= 2 keeps this at 1 bit or more.
  function automatic int gate_w(input int gate_cycles);
    return (gate_cycles > 1) ? $clog2(gate_cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_to_dig_mc_chan.sv
// ----------------------------------------------------------------------------
// ftd_chan_counter
//   One measurement channel: synchroniser, rising-edge detector, saturating
//   edge counter with a sticky saturation flag, and the result register that
//   holds the last completed measurement.
//
// Ports
//   clk     in   1   reference clock (F_REF)
//   rst_n   in   1   asynchronous active-low reset
//   f_in    in   1   measured input, asynchronous to clk
//   clr     in   1   hold the counter and saturation flag at zero
//   en      in   1   count synchronised rising edges this cycle
//   latch   in   1   terminal gate cycle: capture count (including this
//                    cycle's edge) and saturation flag into the result
//   reload  in   1   terminal gate cycle in continuous mode: restart the
//                    counter at zero for the window beginning next cycle
//   count   out  W   latched count of the last completed window
//   ovf     out  1   an edge was dropped by saturation in that window
// ----------------------------------------------------------------------------
module ftd_chan_counter #(
  parameter int W           = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         f_in,
  input  logic         clr,
  input  logic         en,
  input  logic         latch,
  input  logic         reload,
  output logic [W-1:0] count,
  output logic         ovf
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_q;
  logic                   rise;
  logic [W-1:0]           cnt;
  logic                   sat;
  logic [W-1:0]           cnt_next;
  logic                   lost;

  // Synchroniser and edge detector run in every state so that the edge
  // history is already settled when a window opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      s_q  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], f_in};
      s_q  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~s_q;

  // Saturating add of the 1-bit edge; an edge arriving at the ceiling is
  // the event that marks the window as saturated.
  always_comb begin
    cnt_next = cnt;
    lost     = 1'b0;
    if (rise) begin
      if (cnt == CNT_MAX) begin
        lost = 1'b1;
      end else begin
        cnt_next = cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (en) begin
      if (reload) begin
        // The terminal edge goes to the result below; the next window
        // starts clean so nothing is counted twice.
        cnt <= '0;
        sat <= 1'b0;
      end else begin
        cnt <= cnt_next;
        sat <= sat | lost;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (latch) begin
      count <= cnt_next;
      ovf   <= sat | lost;
    end
  end

endmodule

// File: rtl/freq_to_dig_mc.sv
// ----------------------------------------------------------------------------
// freq_to_dig_mc
//   Multi-channel frequency-to-digital converter. Counts rising edges of NCH
//   asynchronous inputs over a window of GATE_CYCLES reference cycles and
//   reports one saturating count per channel. Single-shot or continuous
//   (back-to-back windows with no dead time).
//
// Ports
//   F_REF  in   1      reference clock, all state on its rising edge
//   rst_n  in   1      asynchronous active-low reset
//   f_in   in   NCH    measured inputs, asynchronous to F_REF
//   start  in   1      rising edge while idle starts a measurement
//   cont   in   1      continuous mode, sampled in each terminal gate cycle
//   out_d  out  NCH*W  latched counts, channel i at [i*W +: W]
//   ovf    out  NCH    per-channel saturation flag of the latched window
//   done   out  1      one-cycle pulse when out_d/ovf update
//   busy   out  1      high while arming or gating
// ----------------------------------------------------------------------------
module freq_to_dig_mc
  import freq_to_dig_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 12,
  parameter int GATE_CYCLES = 4096,
  parameter int SYNC_STAGES = 2
) (
  input  logic             F_REF,
  input  logic             rst_n,
  input  logic [NCH-1:0]   f_in,
  input  logic             start,
  input  logic             cont,
  output logic [NCH*W-1:0] out_d,
  output logic [NCH-1:0]   ovf,
  output logic             done,
  output logic             busy
);

  localparam int            GW        = gate_w(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  state_t        state;
  logic [GW-1:0] gate_cnt;
  logic          start_q;
  logic          terminal;
  logic          ch_clr;
  logic          ch_en;
  logic          ch_latch;
  logic          ch_reload;

  assign terminal  = (state == GATE) && (gate_cnt == GATE_LAST);
  assign ch_clr    = (state != GATE);
  assign ch_en     = (state == GATE);
  assign ch_latch  = terminal;
  assign ch_reload = terminal & cont;

  // Sequencer. done and busy are registered so they line up with the
  // result registers in the channel slices.
  always_ff @(posedge F_REF or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      start_q  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start & ~start_q) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          gate_cnt <= '0;
          state    <= GATE;
        end
        GATE: begin
          if (terminal) begin
            done     <= 1'b1;
            gate_cnt <= '0;
            if (!cont) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    ftd_chan_counter #(
      .W           (W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk    (F_REF),
      .rst_n  (rst_n),
      .f_in   (f_in[i]),
      .clr    (ch_clr),
      .en     (ch_en),
      .latch  (ch_latch),
      .reload (ch_reload),
      .count  (out_d[i*W +: W]),
      .ovf    (ovf[i])
    );
  end

endmodule

// File: tb/tb_freq_to_dig_mc.sv
module tb_freq_to_dig_mc;

  localparam int G   = 64;
  localparam int SS  = 2;
  localparam int WM  = 12;
  localparam int WS  = 4;
  localparam int SMX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    f_in;
  logic          start;
  logic          cont;
  logic [4*WM-1:0] out_m;
  logic [3:0]    ovf_m;
  logic          done_m, busy_m;
  logic [2*WS-1:0] out_s;
  logic [1:0]    ovf_s;
  logic          done_s, busy_s;

  always #5 clk = ~clk;

  freq_to_dig_mc #(.NCH(4), .W(WM), .GATE_CYCLES(G), .SYNC_STAGES(SS)) u_main (
    .F_REF(clk), .rst_n(rst_n), .f_in(f_in), .start(start), .cont(cont),
    .out_d(out_m), .ovf(ovf_m), .done(done_m), .busy(busy_m));

  freq_to_dig_mc #(.NCH(2), .W(WS), .GATE_CYCLES(G), .SYNC_STAGES(SS)) u_sat (
    .F_REF(clk), .rst_n(rst_n), .f_in(f_in[1:0]), .start(start), .cont(cont),
    .out_d(out_s), .ovf(ovf_s), .done(done_s), .busy(busy_s));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus modes per channel: >0 period, 0 low, -1 random, -2 pulse.
  int per [4];
  int ph [4];
  int pulse_at [4];

  // Reference model: each driven rising edge is recorded with the cycle in
  // which the synchronised edge is visible (drive cycle + SYNC_STAGES).
  typedef struct { int ch; int eff; } ev_t;
  ev_t evq[$];

  typedef struct {
    int per [4];
    int nwin;
    int drop;
    int exp [4];
  } vec_t;
  vec_t tbl [5];

  function automatic logic gen(input int c);
    if (per[c] > 0)  return ((cyc + ph[c]) % per[c]) < (per[c] / 2);
    if (per[c] == -1) return 1'($urandom % 2);
    if (per[c] == -2) return (cyc >= pulse_at[c]) && (cyc < pulse_at[c] + 2);
    return 1'b0;
  endfunction

  function automatic int count_edges(input int c, input int lo, input int hi);
    int n = 0;
    foreach (evq[i]) if (evq[i].ch == c && evq[i].eff >= lo && evq[i].eff <= hi) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [3:0] nv;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      nv[c] = gen(c);
      if (nv[c] && !f_in[c]) evq.push_back('{c, cyc + SS});
    end
    f_in = nv;
  endtask

  task automatic idle_check(input int n, input string tag);
    int dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done_m || done_s) dones++;
    end
    check({tag, "_no_done"}, 64'(dones), 64'd0);
    check({tag, "_busy_low"}, 64'(busy_m), 64'd0);
  endtask

  // Start a measurement of nwin windows; cont drops during window drop.
  task automatic shot(input int pre, input int nwin, input int drop, input logic use_tbl,
                      input int exp_tbl [4], input logic poke, input string tag);
    int t, lo, hi, d, early, e, es;
    evq.delete();
    repeat (pre) tick();
    tick();
    start = 1'b1;
    cont  = (nwin > 1);
    t     = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < nwin; k++) begin
      lo    = t + 2 + k * G;
      hi    = t + 1 + (k + 1) * G;
      d     = hi + 1;
      early = 0;
      while (cyc < d) begin
        tick();
        if (k == drop && cyc == lo + 10) cont = 1'b0;
        if (poke && cyc == lo + 20) start = 1'b1;
        if (poke && cyc == lo + 22) start = 1'b0;
        if (cyc == lo + 5) check({tag, "_busy_in_gate"}, 64'(busy_m), 64'd1);
        if (cyc < d && (done_m || done_s)) early++;
      end
      check({tag, "_early_done"}, 64'(early), 64'd0);
      check({tag, "_done_m"}, 64'(done_m), 64'd1);
      check({tag, "_done_s"}, 64'(done_s), 64'd1);
      check({tag, "_busy_at_done"}, 64'(busy_m), 64'(k < nwin - 1));
      for (int c = 0; c < 4; c++) begin
        e = use_tbl ? exp_tbl[c] : count_edges(c, lo, hi);
        check($sformatf("%s_w%0d_out_m%0d", tag, k, c), 64'(out_m[c*WM +: WM]), 64'(e));
        check($sformatf("%s_w%0d_ovf_m%0d", tag, k, c), 64'(ovf_m[c]), 64'd0);
        if (c < 2) begin
          es = (e > SMX) ? SMX : e;
          check($sformatf("%s_w%0d_out_s%0d", tag, k, c), 64'(out_s[c*WS +: WS]), 64'(es));
          check($sformatf("%s_w%0d_ovf_s%0d", tag, k, c), 64'(ovf_s[c]), 64'(e > SMX));
        end
      end
    end
    cont = 1'b0;
  endtask

  int none [4];

  initial begin
    tbl[0] = '{per: '{4, 8, 16, 2},  nwin: 1, drop: -1, exp: '{16, 8, 4, 32}};
    tbl[1] = '{per: '{2, 16, 0, 32}, nwin: 1, drop: -1, exp: '{32, 4, 0, 2}};
    tbl[2] = '{per: '{16, 4, 64, 8}, nwin: 1, drop: -1, exp: '{4, 16, 1, 8}};
    tbl[3] = '{per: '{4, 4, 8, 2},   nwin: 5, drop: 4,  exp: '{16, 16, 8, 32}};
    tbl[4] = '{per: '{4, 2, 32, 16}, nwin: 3, drop: 2,  exp: '{16, 32, 2, 4}};
    none   = '{0, 0, 0, 0};

    // Reset with random inputs.
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; f_in = '0;
    per = '{-1, -1, -1, -1};
    pulse_at = '{0, 0, 0, 0};
    repeat (5) tick();
    check("rst_out_m", 64'(out_m), 64'd0);
    check("rst_ovf_m", 64'(ovf_m), 64'd0);
    check("rst_done", 64'({done_m, done_s}), 64'd0);
    check("rst_busy", 64'({busy_m, busy_s}), 64'd0);
    check("rst_out_s", 64'({ovf_s, out_s}), 64'd0);
    rst_n = 1'b1;
    idle_check(40, "post_rst");

    // Table-driven shots and continuous runs.
    for (int i = 0; i < 5; i++) begin
      per = tbl[i].per;
      for (int c = 0; c < 4; c++) ph[c] = int'($urandom % 64);
      shot(2, tbl[i].nwin, tbl[i].drop, 1'b1, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
      idle_check(G + 10, $sformatf("tbl%0d_after", i));
    end

    // Random inputs against the reference model, with start pokes mid-gate.
    per = '{-1, -1, -1, -1};
    shot(2, 1, -1, 1'b0, none, 1'b1, "rnd_single");
    idle_check(G + 10, "rnd_single_after");
    shot(2, 3, 2, 1'b0, none, 1'b1, "rnd_cont");
    idle_check(G + 10, "rnd_cont_after");

    // Reset in the middle of a window: outputs clear, no done, window lost.
    begin
      int t, dones;
      per = '{2, 2, 4, 8};
      repeat (3) tick();
      tick();
      start = 1'b1;
      t = cyc;
      tick();
      start = 1'b0;
      while (cyc < t + 2 + 30) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_out_m", 64'(out_m), 64'd0);
      check("midrst_ovf", 64'({ovf_m, ovf_s}), 64'd0);
      check("midrst_out_s", 64'(out_s), 64'd0);
      check("midrst_busy", 64'({busy_m, busy_s}), 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      dones = 0;
      while (cyc < t + 2 + G + 10) begin
        tick();
        if (done_m || done_s) dones++;
      end
      check("midrst_no_done", 64'(dones), 64'd0);
      check("midrst_busy_after", 64'(busy_m), 64'd0);
    end
    per = tbl[0].per;
    shot(2, 1, -1, 1'b1, tbl[0].exp, 1'b0, "fresh");

    // Edges placed on the window boundaries; t will be cyc + pre + 1.
    begin
      int tb;
      evq.delete();
      per = '{-2, -2, -2, -2};
      tb = cyc + 4 + 1;
      pulse_at[0] = tb + 1 + G - SS;   // terminal cycle of window 0
      pulse_at[1] = tb + 2 + G - SS;   // first cycle of window 1
      pulse_at[2] = tb + 1 - SS;       // ARM cycle, discarded
      pulse_at[3] = tb + 2 - SS;       // first gate cycle
      shot(4, 2, 1, 1'b0, none, 1'b0, "bound");
    end
    idle_check(20, "end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
